// File: rtl/mcb_port_responder_if.sv
// rtl/mcb_port_responder_if.sv - MCB-style user port bundle (command, write-data, read-data)
// Signals: calib_done, cmd_* (command FIFO), wr_* (write FIFO), rd_* (read FIFO).
// Optional sticky error flags exist only when MCB_RESP_ERR_EN is defined.
// Modports: master (port user / controller side), slave (responder side).
interface mcb_port_responder_if;
    logic        calib_done;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full;
    logic        cmd_empty;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        wr_empty;
    logic [6:0]  wr_count;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_full;
    logic        rd_empty;
    logic [6:0]  rd_count;
`ifdef MCB_RESP_ERR_EN
    logic        wr_underrun;
    logic        rd_overflow;
    logic        cmd_drop;
`endif

    modport master (
`ifdef MCB_RESP_ERR_EN
        input  wr_underrun, input rd_overflow, input cmd_drop,
`endif
        input  calib_done,
        output cmd_en, output cmd_instr, output cmd_bl, output cmd_byte_addr,
        input  cmd_full, input cmd_empty,
        output wr_en, output wr_mask, output wr_data,
        input  wr_full, input wr_empty, input wr_count,
        output rd_en,
        input  rd_data, input rd_full, input rd_empty, input rd_count
    );

    modport slave (
`ifdef MCB_RESP_ERR_EN
        output wr_underrun, output rd_overflow, output cmd_drop,
`endif
        output calib_done,
        input  cmd_en, input cmd_instr, input cmd_bl, input cmd_byte_addr,
        output cmd_full, output cmd_empty,
        input  wr_en, input wr_mask, input wr_data,
        output wr_full, output wr_empty, output wr_count,
        input  rd_en,
        output rd_data, output rd_full, output rd_empty, output rd_count
    );
endinterface

// File: rtl/mcb_port_responder.sv
// rtl/mcb_port_responder.sv - block-RAM backed responder for one MCB-style user port
// Ports: clk (rising edge), resetn (async active-low), port (mcb_port_responder_if.slave).
// Optional macro MCB_RESP_ERR_EN adds sticky wr_underrun / rd_overflow / cmd_drop flags.
module mcb_port_responder #(
    parameter int ADDR_WIDTH   = 12,
    parameter int CMD_DEPTH    = 4,
    parameter int DATA_DEPTH   = 64,
    parameter int CALIB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    mcb_port_responder_if.slave   port
);
    localparam int CPW  = $clog2(CMD_DEPTH);
    localparam int DPW  = $clog2(DATA_DEPTH);
    localparam int CW   = 3 + 6 + ADDR_WIDTH;
    localparam int CALW = $clog2(CALIB_CYCLES + 1);
    localparam logic [6:0]     DATA_FULL = 7'(DATA_DEPTH);
    localparam logic [CPW:0]   CMD_FULL  = (CPW + 1)'(CMD_DEPTH);
    localparam logic [CALW-1:0] CALIB_LAST = CALW'(CALIB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [6:0]            beats;
    logic                  rd_inflight;

    // Calibration
    logic [CALW-1:0] calib_cnt;
    logic            calib_done_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            calib_cnt    <= '0;
            calib_done_q <= 1'b0;
        end else if (!calib_done_q) begin
            if (calib_cnt == CALIB_LAST)
                calib_done_q <= 1'b1;
            calib_cnt <= calib_cnt + CALW'(1);
        end
    end

    // Command FIFO: {instr, bl, word address}
    logic [CW-1:0]  cmd_mem [CMD_DEPTH];
    logic [CPW-1:0] cmd_wptr, cmd_rptr;
    logic [CPW:0]   cmd_cnt;
    logic           cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [CW-1:0]  cmd_head;
    logic [2:0]     head_instr;
    logic [5:0]     head_bl;
    logic [ADDR_WIDTH-1:0] head_addr;

    assign cmd_full   = (cmd_cnt == CMD_FULL);
    assign cmd_empty  = (cmd_cnt == '0);
    assign cmd_push   = port.cmd_en && calib_done_q && !cmd_full;
    assign cmd_pop    = (state == IDLE) && !cmd_empty;
    assign cmd_head   = cmd_mem[cmd_rptr];
    assign head_instr = cmd_head[CW-1 -: 3];
    assign head_bl    = cmd_head[ADDR_WIDTH +: 6];
    assign head_addr  = cmd_head[ADDR_WIDTH-1:0];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{port.cmd_byte_addr[29:ADDR_WIDTH+2], port.cmd_byte_addr[1:0]};

    // Write FIFO: {mask, data}
    logic [35:0]    wr_mem [DATA_DEPTH];
    logic [DPW-1:0] wr_wptr, wr_rptr;
    logic [6:0]     wr_cnt;
    logic           wr_full, wr_empty, wr_push, wr_pop;
    logic [35:0]    wr_head;

    assign wr_full  = (wr_cnt == DATA_FULL);
    assign wr_empty = (wr_cnt == 7'd0);
    assign wr_push  = port.wr_en && calib_done_q && !wr_full;
    assign wr_pop   = (state == WRITE) && (beats != 7'd0) && !wr_empty;
    assign wr_head  = wr_mem[wr_rptr];

    // Read FIFO, first-word fall-through
    logic [31:0]    rd_mem [DATA_DEPTH];
    logic [DPW-1:0] rd_wptr, rd_rptr;
    logic [6:0]     rd_cnt;
    logic           rd_full, rd_empty, rd_push, rd_pop, rd_issue;
    logic [31:0]    ram_q;

    assign rd_full  = (rd_cnt == DATA_FULL);
    assign rd_empty = (rd_cnt == 7'd0);
    // A read in flight already owns a slot, so the push can never hit a full FIFO.
    assign rd_push  = rd_inflight;
    assign rd_pop   = port.rd_en && calib_done_q && !rd_empty;
    assign rd_issue = (state == READ) && (beats != 7'd0) &&
                      ((rd_cnt + 7'(rd_inflight)) < DATA_FULL);

    // Storage arrays carry no reset; only pointers and counts do.
    logic [31:0] ram [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wptr] <= {port.cmd_instr, port.cmd_bl,
                                  port.cmd_byte_addr[ADDR_WIDTH+1:2]};
        if (wr_push)
            wr_mem[wr_wptr] <= {port.wr_mask, port.wr_data};
        if (rd_push)
            rd_mem[rd_wptr] <= ram_q;
        if (wr_pop) begin
            for (int b = 0; b < 4; b++)
                if (!wr_head[32 + b])
                    ram[addr][8*b +: 8] <= wr_head[8*b +: 8];
        end
        if (rd_issue)
            ram_q <= ram[addr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_wptr <= '0; cmd_rptr <= '0; cmd_cnt <= '0;
            wr_wptr  <= '0; wr_rptr  <= '0; wr_cnt  <= '0;
            rd_wptr  <= '0; rd_rptr  <= '0; rd_cnt  <= '0;
        end else begin
            if (cmd_push) cmd_wptr <= cmd_wptr + CPW'(1);
            if (cmd_pop)  cmd_rptr <= cmd_rptr + CPW'(1);
            if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + (CPW + 1)'(1);
            else if (!cmd_push && cmd_pop) cmd_cnt <= cmd_cnt - (CPW + 1)'(1);

            if (wr_push) wr_wptr <= wr_wptr + DPW'(1);
            if (wr_pop)  wr_rptr <= wr_rptr + DPW'(1);
            if (wr_push && !wr_pop)      wr_cnt <= wr_cnt + 7'd1;
            else if (!wr_push && wr_pop) wr_cnt <= wr_cnt - 7'd1;

            if (rd_push) rd_wptr <= rd_wptr + DPW'(1);
            if (rd_pop)  rd_rptr <= rd_rptr + DPW'(1);
            if (rd_push && !rd_pop)      rd_cnt <= rd_cnt + 7'd1;
            else if (!rd_push && rd_pop) rd_cnt <= rd_cnt - 7'd1;
        end
    end

    // Burst sequencer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            addr        <= '0;
            beats       <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            case (state)
                IDLE: begin
                    if (cmd_pop) begin
                        addr  <= head_addr;
                        beats <= 7'(head_bl) + 7'd1;
                        case (head_instr)
                            3'b000, 3'b010: state <= WRITE;
                            3'b001, 3'b011: state <= READ;
                            default:        state <= IDLE;
                        endcase
                    end
                end
                WRITE: begin
                    if (wr_pop) begin
                        addr  <= addr + ADDR_WIDTH'(1);
                        beats <= beats - 7'd1;
                        if (beats == 7'd1)
                            state <= IDLE;
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr  <= addr + ADDR_WIDTH'(1);
                        beats <= beats - 7'd1;
                    end else if (beats == 7'd0 && !rd_inflight) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MCB_RESP_ERR_EN
    logic wr_underrun_q, rd_overflow_q, cmd_drop_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_underrun_q <= 1'b0;
            rd_overflow_q <= 1'b0;
            cmd_drop_q    <= 1'b0;
        end else begin
            if (state == WRITE && beats != 7'd0 && wr_empty)
                wr_underrun_q <= 1'b1;
            if (port.rd_en && rd_empty)
                rd_overflow_q <= 1'b1;
            if (port.cmd_en && (cmd_full || !calib_done_q))
                cmd_drop_q <= 1'b1;
        end
    end

    assign port.wr_underrun = wr_underrun_q;
    assign port.rd_overflow = rd_overflow_q;
    assign port.cmd_drop    = cmd_drop_q;
`endif

    assign port.calib_done = calib_done_q;
    assign port.cmd_full   = cmd_full;
    assign port.cmd_empty  = cmd_empty;
    assign port.wr_full    = wr_full;
    assign port.wr_empty   = wr_empty;
    assign port.wr_count   = wr_cnt;
    assign port.rd_full    = rd_full;
    assign port.rd_empty   = rd_empty;
    assign port.rd_count   = rd_cnt;
    assign port.rd_data    = rd_empty ? 32'd0 : rd_mem[rd_rptr];
endmodule

// File: tb/tb_mcb_port_responder.sv
// tb/tb_mcb_port_responder.sv - self-checking bench for mcb_port_responder
module tb_mcb_port_responder;
    logic clk = 1'b0;
    logic resetn;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    mcb_port_responder_if bus ();

    mcb_port_responder #(
        .ADDR_WIDTH   (12),
        .CMD_DEPTH    (4),
        .DATA_DEPTH   (64),
        .CALIB_CYCLES (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .port   (bus.slave)
    );

    typedef struct {
        logic [29:0] wr_addr;
        logic [29:0] rd_addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        bus.cmd_en = 1'b1;
        bus.cmd_instr = instr;
        bus.cmd_bl = bl;
        bus.cmd_byte_addr = addr;
        tick();
        bus.cmd_en = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] data, input logic [3:0] mask);
        bus.wr_en = 1'b1;
        bus.wr_data = data;
        bus.wr_mask = mask;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [31:0] exp);
        check({name, "_nonempty"}, 32'(bus.rd_empty), 32'd0);
        check(name, bus.rd_data, exp);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic wait_rd_count(input int n, input string name);
        int cyc = 0;
        while (int'(bus.rd_count) != n && cyc < 500) begin
            tick();
            cyc++;
        end
        check(name, 32'(bus.rd_count), 32'(n));
    endtask

    task automatic wait_wr_empty(input string name);
        int cyc = 0;
        while (bus.wr_empty !== 1'b1 && cyc < 500) begin
            tick();
            cyc++;
        end
        check(name, 32'(bus.wr_empty), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{30'h200,  30'h200, 32'hA5A5A5A5, 4'b0000, 32'hA5A5A5A5};
        vecs[1] = '{30'h200,  30'h200, 32'h12345678, 4'b0101, 32'h12A556A5};
        vecs[2] = '{30'h200,  30'h200, 32'hFFFFFFFF, 4'b1111, 32'h12A556A5};
        vecs[3] = '{30'h203,  30'h200, 32'h00000000, 4'b1110, 32'h12A55600};
        vecs[4] = '{30'h204,  30'h204, 32'hDEADBEEF, 4'b0000, 32'hDEADBEEF};
        vecs[5] = '{30'h4204, 30'h204, 32'h0BADF00D, 4'b0000, 32'h0BADF00D};

        resetn = 1'b0;
        bus.cmd_en = 1'b0; bus.cmd_instr = 3'b000; bus.cmd_bl = 6'd0; bus.cmd_byte_addr = 30'd0;
        bus.wr_en = 1'b0; bus.wr_mask = 4'b0000; bus.wr_data = 32'd0; bus.rd_en = 1'b0;
        repeat (3) tick();

        check("rst_calib_done", 32'(bus.calib_done), 32'd0);
        check("rst_cmd_empty",  32'(bus.cmd_empty),  32'd1);
        check("rst_cmd_full",   32'(bus.cmd_full),   32'd0);
        check("rst_wr_empty",   32'(bus.wr_empty),   32'd1);
        check("rst_wr_full",    32'(bus.wr_full),    32'd0);
        check("rst_wr_count",   32'(bus.wr_count),   32'd0);
        check("rst_rd_empty",   32'(bus.rd_empty),   32'd1);
        check("rst_rd_full",    32'(bus.rd_full),    32'd0);
        check("rst_rd_count",   32'(bus.rd_count),   32'd0);
        check("rst_rd_data",    bus.rd_data,         32'd0);

        // Calibration window with an early command and write word
        resetn = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            if (c == 5) begin
                bus.cmd_en = 1'b1; bus.cmd_instr = 3'b001;
                bus.wr_en = 1'b1;  bus.wr_data = 32'h1;
            end
            tick();
            bus.cmd_en = 1'b0;
            bus.wr_en = 1'b0;
            if (c == 6) begin
                check("early_cmd_empty", 32'(bus.cmd_empty), 32'd1);
                check("early_wr_empty",  32'(bus.wr_empty),  32'd1);
            end
            if (c == 15) check("calib_c15", 32'(bus.calib_done), 32'd0);
            if (c == 16) check("calib_c16", 32'(bus.calib_done), 32'd1);
        end

        // Pop while empty is ignored; no-op instruction is consumed
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("pop_empty_count", 32'(bus.rd_count), 32'd0);
        issue_cmd(3'b111, 6'd5, 30'd0);
        repeat (4) tick();
        check("noop_cmd_empty", 32'(bus.cmd_empty), 32'd1);
        check("noop_rd_count",  32'(bus.rd_count),  32'd0);

        // Table-driven single-word write/read vectors
        for (int i = 0; i < 6; i++) begin
            push_word(vecs[i].wdata, vecs[i].wmask);
            issue_cmd((i % 2 == 1) ? 3'b010 : 3'b000, 6'd0, vecs[i].wr_addr);
            issue_cmd((i % 2 == 1) ? 3'b011 : 3'b001, 6'd0, vecs[i].rd_addr);
            wait_rd_count(1, $sformatf("vec%0d_wait", i));
            pop_check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Four-word burst write then read
        for (int i = 0; i < 4; i++) push_word(32'h11111111 * (i + 1), 4'b0000);
        check("burst_wr_count", 32'(bus.wr_count), 32'd4);
        issue_cmd(3'b000, 6'd3, 30'h100);
        issue_cmd(3'b001, 6'd3, 30'h100);
        wait_rd_count(4, "burst_wait");
        for (int i = 0; i < 4; i++)
            pop_check($sformatf("burst%0d", i), 32'h11111111 * (i + 1));

        // Masked overwrite, then read with latency check
        push_word(32'hFFFFFFFF, 4'b1100);
        issue_cmd(3'b000, 6'd0, 30'h100);
        repeat (5) tick();
        issue_cmd(3'b001, 6'd0, 30'h100);
        tick();
        tick();
        check("lat_e2_rd_empty", 32'(bus.rd_empty), 32'd1);
        tick();
        check("lat_e3_rd_empty", 32'(bus.rd_empty), 32'd0);
        pop_check("masked", 32'h1111FFFF);

        // 64-word write, then read with backpressure
        for (int i = 0; i < 64; i++) push_word(32'hC0000000 + i, 4'b0000);
        check("wfull_count", 32'(bus.wr_count), 32'd64);
        check("wfull_flag",  32'(bus.wr_full),  32'd1);
        issue_cmd(3'b010, 6'd63, 30'h400);
        wait_wr_empty("bp_wr_drain");
        issue_cmd(3'b011, 6'd63, 30'h400);
        wait_rd_count(64, "bp_wait");
        repeat (10) tick();
        check("bp_rd_count", 32'(bus.rd_count), 32'd64);
        check("bp_rd_full",  32'(bus.rd_full),  32'd1);
        for (int i = 0; i < 64; i++)
            pop_check($sformatf("bp%0d", i), 32'hC0000000 + i);
        check("bp_rd_empty_after", 32'(bus.rd_empty), 32'd1);

        // Address wrap from the last word to word 0
        push_word(32'hAAAA0001, 4'b0000);
        push_word(32'hAAAA0002, 4'b0000);
        issue_cmd(3'b000, 6'd1, 30'h3FFC);
        issue_cmd(3'b001, 6'd0, 30'h3FFC);
        wait_rd_count(1, "wrap_wait_hi");
        pop_check("wrap_hi", 32'hAAAA0001);
        issue_cmd(3'b001, 6'd0, 30'h0);
        wait_rd_count(1, "wrap_wait_lo");
        pop_check("wrap_lo", 32'hAAAA0002);

        // Write-data stall: 3 of 8 words queued
        for (int i = 0; i < 3; i++) push_word(32'h50000000 + i, 4'b0000);
        issue_cmd(3'b000, 6'd7, 30'h800);
        repeat (20) tick();
        check("stall_wr_empty", 32'(bus.wr_empty), 32'd1);
        issue_cmd(3'b001, 6'd0, 30'h800);
        repeat (10) tick();
        check("stall_cmd_pending", 32'(bus.cmd_empty), 32'd0);
        check("stall_rd_count",    32'(bus.rd_count),  32'd0);
`ifdef MCB_RESP_ERR_EN
        check("stall_wr_underrun", 32'(bus.wr_underrun), 32'd1);
`endif
        for (int i = 3; i < 8; i++) push_word(32'h50000000 + i, 4'b0000);
        wait_rd_count(1, "stall_wait");
        pop_check("stall_first", 32'h50000000);
        issue_cmd(3'b001, 6'd7, 30'h800);
        wait_rd_count(8, "stall_wait8");
        for (int i = 0; i < 8; i++)
            pop_check($sformatf("stall%0d", i), 32'h50000000 + i);

        // Reset asserted mid read burst
        issue_cmd(3'b001, 6'd63, 30'h400);
        issue_cmd(3'b001, 6'd0, 30'h0);
        for (int cyc = 0; cyc < 100 && int'(bus.rd_count) < 5; cyc++) tick();
        check("mid_rd_started", 32'(bus.rd_count >= 7'd5), 32'd1);
        check("mid_cmd_pending", 32'(bus.cmd_empty), 32'd0);
        resetn = 1'b0;
        #1;
        check("mid_rst_rd_empty",  32'(bus.rd_empty),   32'd1);
        check("mid_rst_rd_count",  32'(bus.rd_count),   32'd0);
        check("mid_rst_cmd_empty", 32'(bus.cmd_empty),  32'd1);
        check("mid_rst_calib",     32'(bus.calib_done), 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mcb_port_responder.md
Name: mcb_port_responder

Overview:
- Synthesizable responder for one MIG/MCB-style user port (command, write-data and read-data FIFOs), backed by on-chip block RAM instead of DDR2.
- Stands in for a videoRam port so ddrPort0Controller, ddrPort1Controller and colorModule can be exercised without the memory PHY.
- Single clock domain: the port clock is the core clock.
- Executes queued write and read commands in order, one data word per cycle, with MCB-compatible flag semantics.

Parameters:
- ADDR_WIDTH, 12, word-address width of the backing RAM (2^ADDR_WIDTH 32-bit words).
- CMD_DEPTH, 4, command FIFO depth (power of 2).
- DATA_DEPTH, 64, write-FIFO and read-FIFO depth in words (power of 2, max 64).
- CALIB_CYCLES, 16, clocks from reset release until calib_done asserts.

Ports:
- clk  in  1  port/core clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- calib_done  out  1  memory ready.
- cmd_en  in  1  enqueue command this cycle.
- cmd_instr  in  3  000 write, 001 read, 010 write+AP, 011 read+AP; others no-op.
- cmd_bl  in  6  burst length minus 1 (1..64 words).
- cmd_byte_addr  in  30  byte address.
- cmd_full / cmd_empty  out  1 each  command FIFO flags.
- wr_en  in  1  push write word.
- wr_mask  in  4  byte mask; 1 = byte not written.
- wr_data  in  32  write word.
- wr_full / wr_empty  out  1 each  write FIFO flags.
- wr_count  out  7  write FIFO occupancy.
- rd_en  in  1  pop read word.
- rd_data  out  32  head of read FIFO, first-word fall-through.
- rd_full / rd_empty  out  1 each  read FIFO flags.
- rd_count  out  7  read FIFO occupancy.

Behaviour:
- Reset values:
  - calib_done=0.
  - All FIFOs empty: cmd_empty=1, wr_empty=1, rd_empty=1, cmd_full=0, wr_full=0, rd_full=0, wr_count=0, rd_count=0.
  - rd_data=0.
  - FSM=IDLE. RAM contents are not reset.
- Calibration:
  - Counter runs from reset release; calib_done rises on cycle CALIB_CYCLES and stays high until the next reset.
  - cmd_en, wr_en and rd_en before calib_done are ignored.
- FIFO pushes and pops:
  - A push while full is ignored; a pop while empty is ignored.
  - A simultaneous push and pop leaves the count unchanged.
  - Flags and counts update in the cycle after the edge.
- Address: word address = cmd_byte_addr[ADDR_WIDTH+1:2]. Bits [1:0] and the upper bits are ignored. The burst address increments and wraps modulo 2^ADDR_WIDTH.
- FSM states:
  - IDLE: if the command FIFO is non-empty, pop the head and latch instr, addr and beats=bl+1. Go to WRITE for 000/010, READ for 001/011, otherwise stay in IDLE (no-op consumed).
  - WRITE: each cycle with write FIFO non-empty, pop one word, write unmasked bytes at addr, addr++, beats--. An empty write FIFO stalls the state without error. When beats reaches 0, go to IDLE.
  - READ: issue one RAM read per cycle when rd_count + inflight < DATA_DEPTH. The RAM read latency is 1 cycle, and the word is pushed into the read FIFO on the following cycle. At most 1 read may be in flight. When beats reaches 0 and nothing is in flight, go to IDLE.
- Latency:
  - Read: command accepted → IDLE pop +1 → RAM read +1 → read FIFO push +1. rd_empty deasserts no earlier than 3 cycles after cmd_en.
  - Back-to-back commands: the next command pops in the IDLE cycle after completion.
- Ordering: commands complete strictly in order, so a read after a write to the same address returns the new data.
- Reset asserted mid-burst: everything clears immediately. The partial burst is abandoned and FIFO contents are lost.

Optional Feature:
- Macro: MCB_RESP_ERR_EN.
- When defined, the block adds three sticky error outputs, cleared only by reset:
  - wr_underrun: WRITE state stalled because the write FIFO was empty mid-burst.
  - rd_overflow: rd_en was asserted while rd_empty.
  - cmd_drop: cmd_en arrived while cmd_full or before calib_done.
- In every other respect the behaviour is identical with and without the macro.
- When undefined, these ports do not exist and the error conditions are silently tolerated.

Test Plan:
- Calibration and early commands: release reset, then pulse cmd_en at cycle 5 → calib_done=0 through cycle 15 and 1 at cycle 16; the early command is dropped and cmd_empty stays 1.
- Write then read with mask: push 4 words 0x11111111..0x44444444 with wr_mask=0 to byte_addr 0x100, then read bl=3 from 0x100 → rd_data pops 0x11111111, 0x22222222, 0x33333333, 0x44444444. Repeat the write with word 0xFFFFFFFF and mask 4'b1100, then read → 0x1111FFFF.
- Read backpressure: read bl=63 with rd_en held 0 → rd_count stops at 64 and rd_full=1 with no word lost. Pop everything → 64 sequential values.
- Address wrap: write bl=1 at word 2^ADDR_WIDTH-1 → the second word lands at word 0, confirmed by reading word 0.
- Write-data stall: issue a write command bl=7 with only 3 words queued → FSM holds in WRITE. Supply the remaining 5 words → completes; with MCB_RESP_ERR_EN, wr_underrun=1.
- Reset during a read burst: assert resetn=0 mid-burst → immediately rd_empty=1, cmd_empty=1, calib_done=0.
